// File: rtl/audio_resampler_nch.sv
// N-channel audio sample-clock generator with sample/hold, shift+saturate and stepped volume.
// Latency: audio_out valid 2 cycles after sample_stb. No backpressure: output is a strobe stream.
module audio_resampler_nch #(
    parameter int CLK_HZ   = 31500000,
    parameter int RATE_HZ  = 48000,
    parameter int CHANNELS = 2,
    parameter int IN_W     = 18,
    parameter int SHIFT    = 1,
    parameter int OUT_W    = 16,
    parameter int VOL_BITS = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [CHANNELS*IN_W-1:0]  audio_in,
    input  logic [VOL_BITS-1:0]       volume,
    input  logic                      clip_clr,
    output logic                      clk_audio,
    output logic                      sample_stb,
    output logic [CHANNELS*OUT_W-1:0] audio_out,
    output logic                      out_valid,
    output logic [CHANNELS-1:0]       clip
);

    localparam int ACC_W = $clog2(CLK_HZ) + 1;
    localparam logic [ACC_W:0] ACC_STEP  = (ACC_W+1)'(2 * RATE_HZ);
    localparam logic [ACC_W:0] ACC_LIMIT = (ACC_W+1)'(CLK_HZ);
    localparam int EXT_W = ((IN_W > OUT_W) ? IN_W : OUT_W) + 1;
    localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [VOL_BITS-1:0] VOL_MAX = '1;

    if (2 * RATE_HZ >= CLK_HZ) begin : g_rate_chk
        $error("audio_resampler_nch: 2*RATE_HZ must be below CLK_HZ");
    end
    if (CHANNELS < 1) begin : g_ch_chk
        $error("audio_resampler_nch: CHANNELS must be at least 1");
    end
    if (SHIFT < 0 || SHIFT > IN_W - 2) begin : g_shift_chk
        $error("audio_resampler_nch: SHIFT out of range");
    end

    // Returns {clip_hit, saturated_sample}.
    function automatic logic [OUT_W:0] saturate(input logic [IN_W-1:0] s);
        logic signed [EXT_W-1:0] v;
        v = {{(EXT_W-IN_W){s[IN_W-1]}}, s};
        v = v >>> SHIFT;
        if (v > SAT_MAX) begin
            saturate = {1'b1, SAT_MAX[OUT_W-1:0]};
        end else if (v < SAT_MIN) begin
            saturate = {1'b1, SAT_MIN[OUT_W-1:0]};
        end else begin
            saturate = {1'b0, v[OUT_W-1:0]};
        end
    endfunction

    // Each volume step below maximum halves the level (floor rounding).
    function automatic logic [OUT_W-1:0] scale(input logic [OUT_W-1:0] x,
                                               input logic [VOL_BITS-1:0] vol);
        logic signed [OUT_W-1:0] xs;
        xs = x;
        if (vol == '0) begin
            scale = '0;
        end else begin
            scale = xs >>> (VOL_MAX - vol);
        end
    endfunction

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_nxt;
    logic             wrap;
    logic             stb_nxt;

    always_comb begin
        acc_sum = {1'b0, acc} + ACC_STEP;
        wrap    = (acc_sum >= ACC_LIMIT);
        acc_nxt = acc_sum[ACC_W-1:0];
        if (wrap) begin
            acc_nxt = ACC_W'(acc_sum - ACC_LIMIT);
        end
        stb_nxt = wrap && !clk_audio;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            clk_audio  <= 1'b0;
            sample_stb <= 1'b0;
        end else if (!enable) begin
            acc        <= '0;
            clk_audio  <= 1'b0;
            sample_stb <= 1'b0;
        end else begin
            acc        <= acc_nxt;
            sample_stb <= stb_nxt;
            if (wrap) begin
                clk_audio <= ~clk_audio;
            end
        end
    end

    // Capture happens on the same edge that raises sample_stb, so out_valid lands two cycles later.
    logic [CHANNELS-1:0][IN_W-1:0]  hold_dat;
    logic [VOL_BITS-1:0]            hold_vol;
    logic                           s1_vld;
    logic [CHANNELS-1:0][OUT_W-1:0] s1_dat;
    logic [VOL_BITS-1:0]            s1_vol;
    logic                           s2_vld;
    logic [CHANNELS-1:0][OUT_W-1:0] sat_dat;
    logic [CHANNELS-1:0]            sat_hit;
    logic [CHANNELS-1:0][OUT_W-1:0] vol_dat;

    always_comb begin
        sat_dat = '0;
        sat_hit = '0;
        vol_dat = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            {sat_hit[c], sat_dat[c]} = saturate(hold_dat[c]);
            vol_dat[c]               = scale(s1_dat[c], s1_vol);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_dat  <= '0;
            hold_vol  <= '0;
            s1_vld    <= 1'b0;
            s1_dat    <= '0;
            s1_vol    <= '0;
            s2_vld    <= 1'b0;
            audio_out <= '0;
            out_valid <= 1'b0;
            clip      <= '0;
        end else if (!enable) begin
            hold_dat  <= '0;
            hold_vol  <= '0;
            s1_vld    <= 1'b0;
            s1_dat    <= '0;
            s1_vol    <= '0;
            s2_vld    <= 1'b0;
            audio_out <= '0;
            out_valid <= 1'b0;
            clip      <= '0;
        end else begin
            s1_vld    <= stb_nxt;
            s2_vld    <= s1_vld;
            out_valid <= s2_vld;
            if (stb_nxt) begin
                hold_dat <= audio_in;
                hold_vol <= volume;
            end
            if (s1_vld) begin
                s1_dat <= sat_dat;
                s1_vol <= hold_vol;
            end
            if (s2_vld) begin
                audio_out <= vol_dat;
            end
            // A saturation in the same cycle as clip_clr keeps its flag.
            clip <= (clip & ~{CHANNELS{clip_clr}}) | (s1_vld ? sat_hit : '0);
        end
    end

endmodule

// File: tb/tb_audio_resampler_nch.sv
// Randomized bench for audio_resampler_nch against an arithmetic reference model.
module tb_audio_resampler_nch;

    localparam int CLK_HZ  = 1000;
    localparam int RATE_HZ = 37;
    localparam int CH      = 2;
    localparam int IN_W    = 18;
    localparam int SHIFT   = 1;
    localparam int OUT_W   = 16;
    localparam int VB      = 2;
    localparam int FIRST_RISE = (CLK_HZ + 2*RATE_HZ - 1) / (2*RATE_HZ);
    localparam int PER_LO     = CLK_HZ / RATE_HZ;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b1;
    logic                  enable = 1'b0;
    logic [CH*IN_W-1:0]    audio_in = '0;
    logic [VB-1:0]         volume = '0;
    logic                  clip_clr = 1'b0;
    logic                  clk_audio;
    logic                  sample_stb;
    logic [CH*OUT_W-1:0]   audio_out;
    logic                  out_valid;
    logic [CH-1:0]         clip;

    audio_resampler_nch #(
        .CLK_HZ(CLK_HZ), .RATE_HZ(RATE_HZ), .CHANNELS(CH), .IN_W(IN_W),
        .SHIFT(SHIFT), .OUT_W(OUT_W), .VOL_BITS(VB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .audio_in(audio_in),
        .volume(volume), .clip_clr(clip_clr), .clk_audio(clk_audio),
        .sample_stb(sample_stb), .audio_out(audio_out), .out_valid(out_valid),
        .clip(clip)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                  sc;
        logic [CH*OUT_W-1:0] val;
        logic [CH-1:0]       flags;
    } ent_t;

    int                  checks = 0;
    int                  errors = 0;
    int                  cyc = 0;
    longint              n = 0;
    logic                stb_m = 1'b0;
    logic                ov_m = 1'b0;
    logic                clk_m = 1'b0;
    logic [CH-1:0]       clip_m = '0;
    logic [CH*OUT_W-1:0] out_m = '0;
    ent_t                q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Number of clk_audio toggles after k enabled cycles from a cleared start.
    function automatic longint tog(input longint k);
        return (k * 2 * RATE_HZ) / CLK_HZ;
    endfunction

    // Returns {clip_flag, 16-bit result}.
    function automatic logic [OUT_W:0] ref_ch(input logic [IN_W-1:0] x, input logic [VB-1:0] vol);
        int   v;
        logic cf;
        v  = int'($signed(x));
        v  = v >>> SHIFT;
        cf = 1'b0;
        if (v > 32767) begin
            v  = 32767;
            cf = 1'b1;
        end else if (v < -32768) begin
            v  = -32768;
            cf = 1'b1;
        end
        if (vol == 0) v = 0;
        else v = v >>> (((1 << VB) - 1) - int'(vol));
        return {cf, v[OUT_W-1:0]};
    endfunction

    function automatic ent_t mk_ent(input int sc, input logic [CH*IN_W-1:0] a, input logic [VB-1:0] vol);
        ent_t           e;
        logic [OUT_W:0] r;
        e.sc    = sc;
        e.val   = '0;
        e.flags = '0;
        for (int c = 0; c < CH; c++) begin
            r = ref_ch(a[c*IN_W +: IN_W], vol);
            e.val[c*OUT_W +: OUT_W] = r[OUT_W-1:0];
            e.flags[c] = r[OUT_W];
        end
        return e;
    endfunction

    task automatic clear_model();
        n = 0;
        q.delete();
        clip_m = '0;
        out_m  = '0;
        ov_m   = 1'b0;
        stb_m  = 1'b0;
    endtask

    task automatic step();
        logic [CH*IN_W-1:0] a_p;
        logic [VB-1:0]      v_p;
        logic               en_p;
        logic               clr_p;
        a_p   = audio_in;
        v_p   = volume;
        en_p  = enable;
        clr_p = clip_clr;
        @(posedge clk);
        #1;
        cyc++;
        if (!en_p) begin
            clear_model();
        end else begin
            n++;
            stb_m  = (tog(n) != tog(n-1)) && (tog(n) % 2 == 1);
            clip_m = clip_m & ~{CH{clr_p}};
            ov_m   = 1'b0;
            foreach (q[i]) if (q[i].sc == cyc - 1) clip_m = clip_m | q[i].flags;
            if (q.size() > 0 && q[0].sc == cyc - 2) begin
                out_m = q[0].val;
                ov_m  = 1'b1;
                void'(q.pop_front());
            end
            if (stb_m) q.push_back(mk_ent(cyc, a_p, v_p));
        end
        clk_m = (tog(n) % 2 == 1);
        chk("clk_audio", 64'(clk_audio), 64'(clk_m));
        chk("sample_stb", 64'(sample_stb), 64'(stb_m));
        chk("out_valid", 64'(out_valid), 64'(ov_m));
        chk("audio_out", 64'(audio_out), 64'(out_m));
        chk("clip", 64'(clip), 64'(clip_m));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_clk_audio", 64'(clk_audio), 64'd0);
        chk("rst_sample_stb", 64'(sample_stb), 64'd0);
        chk("rst_audio_out", 64'(audio_out), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_clip", 64'(clip), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc++;
        clear_model();
    endtask

    task automatic wait_stb();
        for (int i = 0; i < 200; i++) begin
            step();
            if (sample_stb) return;
        end
        chk("stb_timeout", 64'(sample_stb), 64'd1);
    endtask

    initial begin
        int            cnt;
        longint        last_n;
        logic [15:0]   vexp[4];
        vexp = '{16'h0000, 16'h0080, 16'h0100, 16'h0200};

        #1;
        do_reset();
        enable = 1'b1;

        // Rate and phase over one full CLK_HZ window.
        cnt = 0;
        last_n = 0;
        for (int i = 0; i < CLK_HZ; i++) begin
            audio_in = {18'($urandom), 18'($urandom)};
            volume   = VB'($urandom);
            step();
            if (sample_stb) begin
                if (cnt == 0) chk("first_rise", 64'(n), 64'(FIRST_RISE));
                else chk("period", 64'((n - last_n == PER_LO) || (n - last_n == PER_LO + 1)), 64'd1);
                cnt++;
                last_n = n;
            end
        end
        chk("stb_count", 64'(cnt), 64'(RATE_HZ));

        // Saturation both ways, then clear.
        audio_in = {18'h20000, 18'h1FFFF};
        volume   = 2'd3;
        wait_stb();
        step();
        chk("clip_sat", 64'(clip), 64'h3);
        step();
        chk("sat_out", 64'(audio_out), 64'h8000_7FFF);
        clip_clr = 1'b1;
        step();
        clip_clr = 1'b0;
        chk("clip_clr", 64'(clip), 64'd0);

        // Volume steps.
        audio_in = {18'h0, 18'h00400};
        for (int v = 3; v >= 0; v--) begin
            volume = VB'(v);
            wait_stb();
            step();
            step();
            chk("vol_step", 64'(audio_out[15:0]), 64'(vexp[v]));
        end
        audio_in = {18'h0, 18'h3FFFC};
        volume   = 2'd1;
        wait_stb();
        step();
        step();
        chk("neg_floor", 64'(audio_out[15:0]), 64'hFFFF);

        // Inputs changed right after the strobe must not leak into this sample.
        audio_in = {18'h0, 18'h00400};
        volume   = 2'd3;
        wait_stb();
        step();
        audio_in = {18'h0, 18'h1FFFF};
        volume   = 2'd0;
        step();
        chk("old_vals", 64'(audio_out[15:0]), 64'h0200);
        chk("ov_at_s2", 64'(out_valid), 64'd1);
        step();
        chk("ov_after_s2", 64'(out_valid), 64'd0);

        // Saturation and clip_clr on the same edge.
        wait_stb();
        clip_clr = 1'b1;
        step();
        clip_clr = 1'b0;
        chk("set_wins", 64'(clip[0]), 64'd1);

        // Reset in cycle S+1 aborts the sample.
        volume = 2'd3;
        wait_stb();
        step();
        do_reset();
        for (int i = 0; i < 5; i++) step();
        chk("no_ov_abort", 64'(out_valid), 64'd0);

        // Enable low restarts the phase.
        enable = 1'b0;
        step();
        enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (sample_stb) break;
        end
        chk("restart_rise", 64'(n), 64'(FIRST_RISE));

        // Random traffic with occasional enable drops and clears.
        for (int i = 0; i < 3000; i++) begin
            audio_in = {18'($urandom), 18'($urandom)};
            volume   = VB'($urandom);
            clip_clr = ($urandom_range(0, 15) == 0);
            enable   = ($urandom_range(0, 149) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
